// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - next-PC controller with fixed-priority redirect arbitration
//
// Owns the architectural fetch PC. It advances the PC by 4 on each accepted
// fetch. On a redirect it loads the winning target, bumps the fetch epoch and
// emits a registered one-cycle flush tagged with the winning source.
//
// Optional feature macro: PC_CTRL_MISALIGN_CHECK_EN
//   defined   : a misaligned winning target diverts the PC to TRAP_VEC and
//               raises misalign_exc/misalign_tval alongside the flush.
//   undefined : target bits [1:0] are forced to zero, and misalign outputs are tied 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_redir_valid     per-source redirect request (index 0 = highest priority)
//   i_redir_target    source i target in bits [i*XLEN +: XLEN]
//   o_redir_grant     combinational one-hot winner, 0 if no request
//   o_fetch_valid     fetch_pc valid toward ifetch
//   i_fetch_ready     ifetch accepts fetch_pc
//   o_fetch_pc        current fetch PC
//   o_fetch_epoch     epoch of o_fetch_pc
//   o_flush           one-cycle pipeline flush pulse
//   o_flush_src       one-hot source of the flush, 0 when no flush
//   o_misalign_exc    misaligned redirect, pulses with o_flush
//   o_misalign_tval   offending target, valid with o_misalign_exc

module pc_redirect_ctrl #(
  parameter int          XLEN     = 32,
  parameter int          NSRC     = 3,
  parameter int          EPOCH_W  = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      i_redir_valid,
  input  logic [NSRC*XLEN-1:0] i_redir_target,
  output logic [NSRC-1:0]      o_redir_grant,
  output logic                 o_fetch_valid,
  input  logic                 i_fetch_ready,
  output logic [XLEN-1:0]      o_fetch_pc,
  output logic [EPOCH_W-1:0]   o_fetch_epoch,
  output logic                 o_flush,
  output logic [NSRC-1:0]      o_flush_src,
  output logic                 o_misalign_exc,
  output logic [XLEN-1:0]      o_misalign_tval
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     w_pc_nxt;
  logic [EPOCH_W-1:0]  r_epoch;
  logic [EPOCH_W-1:0]  w_epoch_nxt;
  logic [NSRC-1:0]     r_flush_src;
  logic [NSRC-1:0]     w_flush_src_nxt;

  logic [NSRC-1:0]     w_grant;
  logic [XLEN-1:0]     w_target;
  logic                w_any_redir;
  logic [XLEN-1:0]     w_redir_pc;
  logic                w_misalign;

  // Priority pick: scanning from the top down lets the lowest set index win.
  always_comb begin
    w_grant = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_redir_valid[i]) begin
        w_grant    = '0;
        w_grant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_target = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_grant[i]) begin
        w_target = i_redir_target[i*XLEN +: XLEN];
      end
    end
  end

  assign w_any_redir   = |i_redir_valid;
  assign o_redir_grant = w_grant;

`ifdef PC_CTRL_MISALIGN_CHECK_EN
  logic            r_misalign_exc;
  logic [XLEN-1:0] r_misalign_tval;

  assign w_misalign = w_any_redir && (w_target[1:0] != 2'b00);
  assign w_redir_pc = w_misalign ? XLEN'(TRAP_VEC) : w_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign_exc  <= 1'b0;
      r_misalign_tval <= '0;
    end else begin
      r_misalign_exc  <= w_misalign;
      r_misalign_tval <= w_misalign ? w_target : '0;
    end
  end

  assign o_misalign_exc  = r_misalign_exc;
  assign o_misalign_tval = r_misalign_tval;
`else
  logic w_unused;

  assign w_misalign      = 1'b0;
  assign w_redir_pc      = {w_target[XLEN-1:2], 2'b00};
  assign w_unused        = ^{TRAP_VEC, w_target[1:0], w_misalign};
  assign o_misalign_exc  = 1'b0;
  assign o_misalign_tval = '0;
`endif

  // The redirect is taken identically from every state. A redirect coinciding
  // with a RUN handshake still wins the PC update, so no +4 is applied.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_epoch_nxt     = r_epoch;
    w_flush_src_nxt = '0;
    if (w_any_redir) begin
      w_state_nxt     = FLUSH;
      w_pc_nxt        = w_redir_pc;
      w_epoch_nxt     = r_epoch + EPOCH_W'(1);
      w_flush_src_nxt = w_grant;
    end else begin
      case (r_state)
        BOOT:  w_state_nxt = RUN;
        RUN: begin
          if (i_fetch_ready) begin
            w_pc_nxt = r_pc + XLEN'(4);
          end
        end
        FLUSH: w_state_nxt = RUN;
        default: w_state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BOOT;
      r_pc        <= XLEN'(RESET_PC);
      r_epoch     <= '0;
      r_flush_src <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_epoch     <= w_epoch_nxt;
      r_flush_src <= w_flush_src_nxt;
    end
  end

  assign o_fetch_valid = (r_state == RUN);
  assign o_flush       = (r_state == FLUSH);
  assign o_fetch_pc    = r_pc;
  assign o_fetch_epoch = r_epoch;
  assign o_flush_src   = r_flush_src;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl

module tb_pc_redirect_ctrl;

  localparam int XLEN    = 32;
  localparam int NSRC    = 3;
  localparam int EPOCH_W = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;

  logic [NSRC-1:0]      redir_valid;
  logic [NSRC*XLEN-1:0] redir_target;
  logic [NSRC-1:0]      redir_grant;
  logic                 fetch_valid;
  logic                 fetch_ready;
  logic [XLEN-1:0]      fetch_pc;
  logic [EPOCH_W-1:0]   fetch_epoch;
  logic                 flush;
  logic [NSRC-1:0]      flush_src;
  logic                 misalign_exc;
  logic [XLEN-1:0]      misalign_tval;

  logic [NSRC-1:0]      w_redir_valid;
  logic [NSRC*XLEN-1:0] w_redir_target;
  logic [NSRC-1:0]      w_redir_grant;
  logic                 w_fetch_valid;
  logic                 w_fetch_ready;
  logic [XLEN-1:0]      w_fetch_pc;
  logic [EPOCH_W-1:0]   w_fetch_epoch;
  logic                 w_flush;
  logic [NSRC-1:0]      w_flush_src;
  logic                 w_misalign_exc;
  logic [XLEN-1:0]      w_misalign_tval;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(
    .XLEN(XLEN), .NSRC(NSRC), .EPOCH_W(EPOCH_W),
    .RESET_PC(32'h0000_0000), .TRAP_VEC(32'h0000_0100)
  ) u_dut (
    .clk(clk), .rst(rst),
    .i_redir_valid(redir_valid), .i_redir_target(redir_target),
    .o_redir_grant(redir_grant), .o_fetch_valid(fetch_valid),
    .i_fetch_ready(fetch_ready), .o_fetch_pc(fetch_pc),
    .o_fetch_epoch(fetch_epoch), .o_flush(flush), .o_flush_src(flush_src),
    .o_misalign_exc(misalign_exc), .o_misalign_tval(misalign_tval)
  );

  pc_redirect_ctrl #(
    .XLEN(XLEN), .NSRC(NSRC), .EPOCH_W(EPOCH_W),
    .RESET_PC(32'hFFFF_FFFC), .TRAP_VEC(32'h0000_0100)
  ) u_dut_wrap (
    .clk(clk), .rst(rst),
    .i_redir_valid(w_redir_valid), .i_redir_target(w_redir_target),
    .o_redir_grant(w_redir_grant), .o_fetch_valid(w_fetch_valid),
    .i_fetch_ready(w_fetch_ready), .o_fetch_pc(w_fetch_pc),
    .o_fetch_epoch(w_fetch_epoch), .o_flush(w_flush), .o_flush_src(w_flush_src),
    .o_misalign_exc(w_misalign_exc), .o_misalign_tval(w_misalign_tval)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_target(input int src, input logic [XLEN-1:0] tgt);
    redir_target[src*XLEN +: XLEN] = tgt;
  endtask

  initial begin
    redir_valid    = '0;
    redir_target   = '0;
    fetch_ready    = 1'b0;
    w_redir_valid  = '0;
    w_redir_target = '0;
    w_fetch_ready  = 1'b0;

    tick();
    tick();
    check("rst_valid", 64'(fetch_valid), 64'h0);
    check("rst_pc", 64'(fetch_pc), 64'h0);
    check("rst_epoch", 64'(fetch_epoch), 64'h0);
    check("rst_flush", 64'(flush), 64'h0);
    check("rst_flush_src", 64'(flush_src), 64'h0);
    check("rst_exc", 64'(misalign_exc), 64'h0);
    check("rst_tval", 64'(misalign_tval), 64'h0);
    check("rst_wrap_pc", 64'(w_fetch_pc), 64'hFFFF_FFFC);

    // Grant is purely combinational, so it must show even while held in reset.
    redir_valid = 3'b110;
    #1;
    check("boot_grant", 64'(redir_grant), 64'h2);
    redir_valid = 3'b000;
    #1;
    check("grant_none", 64'(redir_grant), 64'h0);

    fetch_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("first_valid", 64'(fetch_valid), 64'h1);
    check("wrap_first_pc", 64'(w_fetch_pc), 64'hFFFF_FFFC);
    w_fetch_ready = 1'b1;

    for (int i = 0; i < 4; i++) begin
      check("seq_pc", 64'(fetch_pc), 64'(i * 4));
      check("seq_valid", 64'(fetch_valid), 64'h1);
      check("seq_flush", 64'(flush), 64'h0);
      tick();
      w_fetch_ready = 1'b0;
    end
    check("wrap_pc", 64'(w_fetch_pc), 64'h0);

    // Stall at 0x10.
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 64'(fetch_pc), 64'h10);
      check("stall_epoch", 64'(fetch_epoch), 64'h0);
      check("stall_valid", 64'(fetch_valid), 64'h1);
    end

    // Redirect coincident with handshake; source 1 beats source 2.
    fetch_ready = 1'b1;
    set_target(1, 32'h200);
    set_target(2, 32'h300);
    redir_valid = 3'b110;
    #1;
    check("grant_110", 64'(redir_grant), 64'h2);
    tick();
    check("redir_flush", 64'(flush), 64'h1);
    check("redir_src", 64'(flush_src), 64'h2);
    check("redir_pc", 64'(fetch_pc), 64'h200);
    check("redir_epoch", 64'(fetch_epoch), 64'h1);
    check("redir_valid", 64'(fetch_valid), 64'h0);
    check("redir_exc", 64'(misalign_exc), 64'h0);

    // Second redirect inside the FLUSH cycle.
    set_target(0, 32'h400);
    redir_valid = 3'b001;
    tick();
    check("flush2_flush", 64'(flush), 64'h1);
    check("flush2_pc", 64'(fetch_pc), 64'h400);
    check("flush2_epoch", 64'(fetch_epoch), 64'h2);
    check("flush2_src", 64'(flush_src), 64'h1);
    check("flush2_valid", 64'(fetch_valid), 64'h0);

    redir_valid = 3'b000;
    tick();
    check("post_valid", 64'(fetch_valid), 64'h1);
    check("post_flush", 64'(flush), 64'h0);
    check("post_src", 64'(flush_src), 64'h0);
    check("post_pc", 64'(fetch_pc), 64'h400);
    tick();
    check("post_adv_pc", 64'(fetch_pc), 64'h404);
    fetch_ready = 1'b0;

    // Misaligned target.
    set_target(0, 32'h202);
    redir_valid = 3'b001;
    tick();
    check("mis_flush", 64'(flush), 64'h1);
    check("mis_epoch", 64'(fetch_epoch), 64'h3);
`ifdef PC_CTRL_MISALIGN_CHECK_EN
    check("mis_pc", 64'(fetch_pc), 64'h100);
    check("mis_exc", 64'(misalign_exc), 64'h1);
    check("mis_tval", 64'(misalign_tval), 64'h202);
`else
    check("mis_pc", 64'(fetch_pc), 64'h200);
    check("mis_exc", 64'(misalign_exc), 64'h0);
    check("mis_tval", 64'(misalign_tval), 64'h0);
`endif
    redir_valid = 3'b000;
    tick();
    check("mis_clear_exc", 64'(misalign_exc), 64'h0);
    check("mis_clear_valid", 64'(fetch_valid), 64'h1);

    // 16 back-to-back redirects wrap the epoch around to its start value.
    redir_valid = 3'b100;
    for (int k = 0; k < 16; k++) begin
      set_target(2, 32'h1000 + 32'(k * 4));
      tick();
      check("b2b_epoch", 64'(fetch_epoch), 64'((4 + k) % 16));
      check("b2b_flush", 64'(flush), 64'h1);
      check("b2b_src", 64'(flush_src), 64'h4);
      check("b2b_pc", 64'(fetch_pc), 64'(32'h1000 + 32'(k * 4)));
    end
    check("epoch_wrap", 64'(fetch_epoch), 64'h3);
    redir_valid = 3'b000;
    tick();
    check("b2b_end_valid", 64'(fetch_valid), 64'h1);

    // Asynchronous reset while a flush is pending.
    set_target(0, 32'h800);
    redir_valid = 3'b001;
    tick();
    check("pre_rst_flush", 64'(flush), 64'h1);
    redir_valid = 3'b000;
    #1;
    rst = 1'b1;
    #1;
    check("arst_flush", 64'(flush), 64'h0);
    check("arst_pc", 64'(fetch_pc), 64'h0);
    check("arst_epoch", 64'(fetch_epoch), 64'h0);
    check("arst_src", 64'(flush_src), 64'h0);
    check("arst_valid", 64'(fetch_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Parametrised next-PC controller sitting between the redirect producers (ALU branch resolution, pc_gen jumps, commit/trap) and ifetch. It owns the architectural fetch PC register and arbitrates NSRC redirect sources by fixed priority. It advances the PC on each accepted fetch, and on a redirect emits a registered one-cycle flush tagged with the winning source and a new fetch epoch.

## Interface
- XLEN, 32, PC and target width
- NSRC, 3, number of redirect sources; index 0 = highest priority
- EPOCH_W, 4, fetch epoch counter width
- RESET_PC, 32'h0000_0000, PC loaded at reset
- TRAP_VEC, 32'h0000_0100, PC taken on a misaligned redirect (only with macro)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- redir_valid  in  NSRC  per-source redirect request, sampled every cycle, always accepted
- redir_target  in  NSRC*XLEN  source i target in bits [i*XLEN +: XLEN]
- redir_grant  out  NSRC  combinational one-hot of the winning source this cycle, 0 if none
- fetch_valid  out  1  fetch_pc valid toward ifetch
- fetch_ready  in  1  ifetch accepts fetch_pc
- fetch_pc  out  XLEN  current fetch PC (registered)
- fetch_epoch  out  EPOCH_W  epoch of fetch_pc (registered)
- flush  out  1  registered one-cycle pipeline flush pulse
- flush_src  out  NSRC  one-hot source that caused the flush, valid when flush=1, else 0
- misalign_exc  out  1  pulses with flush when a redirect target was misaligned
- misalign_tval  out  XLEN  offending target, valid with misalign_exc

## Operation
- States: BOOT, RUN, FLUSH.
- BOOT: entered on reset. fetch_valid=0. Unconditionally goes to RUN next cycle. A redirect seen in BOOT is taken as in RUN and goes to FLUSH instead.
- RUN: fetch_valid=1.
  - If any redir_valid: winner = lowest index set. pc <= winner target, epoch <= epoch+1, flush_src <= grant. Go to FLUSH.
  - Else, if fetch_ready: pc <= pc+4.
  - Else: hold.
- FLUSH: fetch_valid=0, flush=1.
  - A new redirect here is taken the same way: pc, epoch+1 and flush_src update, and the block stays in FLUSH.
  - Otherwise it returns to RUN.
- Simultaneous redirect and fetch handshake in RUN: the handshake completes, so ifetch has taken the old pc with the old epoch, but the redirect wins the PC update. No +4 is applied.
- Losing sources are dropped silently. Producers re-assert if still needed.
- Arithmetic:
  - pc+4 wraps modulo 2^XLEN.
  - epoch wraps modulo 2^EPOCH_W.
  - ifetch discards responses whose epoch differs from fetch_epoch.
- redir_grant is combinational from redir_valid only. It is asserted in every state, including BOOT.

## Timing
- Reset values:
  - state=BOOT
  - fetch_pc=RESET_PC, fetch_epoch=0
  - fetch_valid=0, flush=0, flush_src=0
  - misalign_exc=0, misalign_tval=0
- First fetch_valid=1 occurs one cycle after rst deasserts.
- Redirect latency: redir_valid sampled at edge N gives the following from cycle N+1:
  - flush=1 and fetch_pc=target for one cycle.
  - fetch_valid=1 at N+2, giving exactly one bubble.
- Back-to-back redirects extend FLUSH one cycle per redirect.
- Sequential advance: fetch_pc steps by one per fetch_valid&fetch_ready cycle, with zero-cycle turnaround.
- fetch_pc, fetch_epoch and fetch_valid are stable while fetch_valid=1 and fetch_ready=0.
- rst mid-operation clears all state asynchronously. Any pending flush is lost.

## Configuration
- PC_CTRL_MISALIGN_CHECK_EN defined:
  - If the winning target has bits [1:0] != 0, pc <= TRAP_VEC (not the target) and flush_src reports the source.
  - misalign_exc=1 and misalign_tval=target during that FLUSH cycle.
  - The epoch increments normally.
- Not defined:
  - The target is loaded with bits [1:0] forced to 0.
  - misalign_exc and misalign_tval are tied to 0.
  - TRAP_VEC is unused.

## Test plan
- Reset release, fetch_ready=1 for 4 cycles -> fetch_valid rises one cycle after release; fetch_pc 0x0, 0x4, 0x8, 0xC; flush stays 0.
- In RUN, redir_valid=3'b110 with targets[1]=0x200 and targets[2]=0x300 -> redir_grant=3'b010; next cycle flush=1, flush_src=3'b010, fetch_pc=0x200, epoch 0->1, fetch_valid=0; following cycle fetch_valid=1.
- Redirect in the FLUSH cycle (source 0, 0x400) -> flush held a second cycle, fetch_pc=0x400, epoch=2, flush_src=3'b001.
- fetch_ready=0 for 3 cycles at pc 0x10 -> pc, epoch and valid stable; then a redirect coincident with fetch_ready=1 -> handshake at 0x10, next pc = target (not 0x14).
- Wrap: RESET_PC=32'hFFFF_FFFC with one handshake -> pc=0x0; 16 redirects with EPOCH_W=4 -> epoch returns to 0.
- Macro on, redirect to 0x202 -> flush=1, fetch_pc=0x100, misalign_exc=1, misalign_tval=0x202. Macro off, same stimulus -> fetch_pc=0x200, misalign_exc=0.
